// File: rtl/decode_in_capture_buffer.sv
// Decode-stage bus capture unit: samples enable_decode/dout/npc_in while armed,
// timestamps each sample and buffers it in a FWFT FIFO drained over valid/ready.
module decode_in_capture_buffer #(
    parameter int INSTR_W     = 16,
    parameter int PC_W        = 16,
    parameter int DEPTH       = 8,
    parameter int TS_W        = 16,
    parameter int CAPTURE_ALL = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     enable_decode,
    input  logic [INSTR_W-1:0]       dout,
    input  logic [PC_W-1:0]          npc_in,
    output logic                     txn_valid,
    input  logic                     txn_ready,
    output logic [INSTR_W-1:0]       txn_dout,
    output logic [PC_W-1:0]          txn_npc,
    output logic                     txn_en,
    output logic [TS_W-1:0]          txn_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              overflow_cnt,
    output logic                     busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] dout;
        logic [PC_W-1:0]    npc;
        logic               en;
        logic [TS_W-1:0]    ts;
    } entry_t;

    entry_t            r_mem [DEPTH];
    state_t            r_state;
    logic              r_busy;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [15:0]       r_ovf;
    logic [TS_W-1:0]   r_ts;

    logic [TS_W-1:0]   w_ts_next;
    logic              w_empty;
    logic              w_full;
    logic              w_capture;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_last_pop;
    entry_t            w_wr_entry;
    entry_t            w_head;

    // A sample is stamped with the counter value that its capture edge produces.
    assign w_ts_next  = r_ts + TS_W'(1);
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_capture  = (r_state == S_RUN) && !stop && (enable_decode || (CAPTURE_ALL != 0));
    assign w_pop      = !w_empty && txn_ready;
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;
    assign w_last_pop = (r_level == LVL_W'(1)) && w_pop;

    assign w_wr_entry = '{dout: dout, npc: npc_in, en: enable_decode, ts: w_ts_next};
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= w_ts_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty || w_last_pop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: storage has no reset; reset empties the FIFO through the pointers
    // and level, and the txn_* outputs are forced to zero while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != 16'hFFFF)) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

    assign txn_valid    = !w_empty;
    assign txn_dout     = txn_valid ? w_head.dout : '0;
    assign txn_npc      = txn_valid ? w_head.npc  : '0;
    assign txn_en       = txn_valid ? w_head.en   : 1'b0;
    assign txn_ts       = txn_valid ? w_head.ts   : '0;
    assign level        = r_level;
    assign overflow_cnt = r_ovf;
    assign busy         = r_busy;

endmodule
